// File: rtl/ps2_mouse_sequencer_if.sv
// PS/2 transmitter, receiver and decoded-packet signals
// shared by the mouse init sequencer and its PHY side.
interface ps2_mouse_sequencer_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       tx_ack;
  logic       tx_error;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       pkt_valid;
  logic [2:0] pkt_btn;
  logic [8:0] pkt_dx;
  logic [8:0] pkt_dy;
  logic [1:0] pkt_ovf;

  modport master (
    output tx_data, tx_start,
    input  tx_busy, tx_ack, tx_error,
    input  rx_data, rx_valid,
    output pkt_valid, pkt_btn, pkt_dx, pkt_dy, pkt_ovf
  );

  modport slave (
    input  tx_data, tx_start,
    output tx_busy, tx_ack, tx_error,
    output rx_data, rx_valid,
    input  pkt_valid, pkt_btn, pkt_dx, pkt_dy, pkt_ovf
  );
endinterface

// File: rtl/ps2_mouse_sequencer.sv
// PS/2 mouse bring-up sequencer: reset/BAT/ID, rate and
// resolution setup, stream enable, then 3-byte packet assembly.
module ps2_mouse_sequencer #(
  parameter int BOOT_DLY  = 2700000,
  parameter int RSP_TMO   = 540000,
  parameter int MAX_RETRY = 3,
  parameter int PKT_TMO   = 54000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] cfg_rate,
  input  logic [1:0] cfg_res,
  ps2_mouse_sequencer_if.master bus,
  output logic       init_done,
  output logic       init_fail,
  output logic [3:0] seq_state
);

  localparam logic [3:0] S_BOOT     = 4'd0;
  localparam logic [3:0] S_SEND     = 4'd1;
  localparam logic [3:0] S_WAIT_TX  = 4'd2;
  localparam logic [3:0] S_WAIT_RSP = 4'd3;
  localparam logic [3:0] S_WAIT_BAT = 4'd4;
  localparam logic [3:0] S_WAIT_ID  = 4'd5;
  localparam logic [3:0] S_STREAM   = 4'd6;
  localparam logic [3:0] S_FAIL     = 4'd7;

  localparam logic [31:0] BOOT_LAST =
    (BOOT_DLY > 0) ? 32'(BOOT_DLY - 1) : 32'd0;
  localparam logic [31:0] RSP_T = 32'(RSP_TMO);
  localparam logic [31:0] BAT_T = 32'(16 * RSP_TMO);
  localparam logic [31:0] PKT_T = 32'(PKT_TMO);
  localparam logic [7:0]  R_MAX = 8'(MAX_RETRY);

  logic [3:0]  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  retry_q, retry_d;
  logic [7:0]  rate_q, rate_d;
  logic [1:0]  res_q, res_d;
  logic [7:0]  txd_q, txd_d;
  logic        txs_q, txs_d;
  logic        bsy_q, bsy_d;
  logic [1:0]  pb_q, pb_d;
  logic [7:0]  b0_q, b0_d;
  logic [7:0]  b1_q, b1_d;
  logic [31:0] gap_q, gap_d;
  logic        pv_q, pv_d;
  logic [2:0]  btn_q, btn_d;
  logic [8:0]  dx_q, dx_d;
  logic [8:0]  dy_q, dy_d;
  logic [1:0]  ovf_q, ovf_d;
  logic [7:0]  cmd_byte;
  logic        retry_req;
  logic        fe_req;

  always_comb begin
    cmd_byte = 8'h00;
    unique case (idx_q)
      3'd0:    cmd_byte = 8'hFF;
      3'd1:    cmd_byte = 8'hF3;
      3'd2:    cmd_byte = rate_q;
      3'd3:    cmd_byte = 8'hE8;
      3'd4:    cmd_byte = {6'b0, res_q};
      3'd5:    cmd_byte = 8'hF4;
      default: cmd_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    retry_d   = retry_q;
    rate_d    = rate_q;
    res_d     = res_q;
    txd_d     = txd_q;
    txs_d     = 1'b0;
    bsy_d     = bsy_q;
    pb_d      = pb_q;
    b0_d      = b0_q;
    b1_d      = b1_q;
    gap_d     = gap_q;
    pv_d      = 1'b0;
    btn_d     = btn_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    ovf_d     = ovf_q;
    retry_req = 1'b0;
    fe_req    = 1'b0;
    unique case (state_q)
      S_BOOT: begin
        if (cnt_q >= BOOT_LAST) begin
          rate_d  = cfg_rate;
          res_d   = cfg_res;
          idx_d   = 3'd0;
          retry_d = 8'd0;
          cnt_d   = 32'd0;
          state_d = S_SEND;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_SEND: begin
        if (!bus.tx_busy) begin
          txd_d   = cmd_byte;
          txs_d   = 1'b1;
          bsy_d   = 1'b0;
          cnt_d   = RSP_T;
          state_d = S_WAIT_TX;
        end
      end
      S_WAIT_TX: begin
        if (bus.tx_busy) bsy_d = 1'b1;
        // ack/error only count once busy has been seen for this byte
        if (bsy_q && !bus.tx_busy) begin
          if (bus.tx_ack && !bus.tx_error) begin
            cnt_d   = RSP_T;
            state_d = S_WAIT_RSP;
          end else begin
            retry_req = 1'b1;
          end
        end else if (cnt_q == 32'd0) begin
          retry_req = 1'b1;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      S_WAIT_RSP: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == 8'hFA) begin
            if (idx_q == 3'd0) begin
              cnt_d   = BAT_T;
              state_d = S_WAIT_BAT;
            end else if (idx_q == 3'd5) begin
              pb_d    = 2'd0;
              gap_d   = 32'd0;
              state_d = S_STREAM;
            end else begin
              idx_d   = idx_q + 3'd1;
              retry_d = 8'd0;
              state_d = S_SEND;
            end
          end else if (bus.rx_data == 8'hFE) begin
            fe_req = 1'b1;
          end else begin
            retry_req = 1'b1;
          end
        end else if (cnt_q == 32'd0) begin
          retry_req = 1'b1;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      S_WAIT_BAT: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == 8'hAA) begin
            cnt_d   = RSP_T;
            state_d = S_WAIT_ID;
          end else begin
            idx_d     = 3'd0;
            retry_req = 1'b1;
          end
        end else if (cnt_q == 32'd0) begin
          idx_d     = 3'd0;
          retry_req = 1'b1;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      S_WAIT_ID: begin
        if (bus.rx_valid) begin
          idx_d   = 3'd1;
          retry_d = 8'd0;
          state_d = S_SEND;
        end else if (cnt_q == 32'd0) begin
          idx_d     = 3'd0;
          retry_req = 1'b1;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      S_STREAM: begin
        if (bus.rx_valid) begin
          gap_d = 32'd0;
          unique case (pb_q)
            2'd0: begin
              if (bus.rx_data[3]) begin
                b0_d = bus.rx_data;
                pb_d = 2'd1;
              end
            end
            2'd1: begin
              b1_d = bus.rx_data;
              pb_d = 2'd2;
            end
            default: begin
              pv_d  = 1'b1;
              btn_d = b0_q[2:0];
              dx_d  = {b0_q[4], b1_q};
              dy_d  = {b0_q[5], bus.rx_data};
              ovf_d = {b0_q[7], b0_q[6]};
              pb_d  = 2'd0;
            end
          endcase
        end else if (pb_q != 2'd0) begin
          if (gap_q >= PKT_T) begin
            pb_d  = 2'd0;
            gap_d = 32'd0;
          end else begin
            gap_d = gap_q + 32'd1;
          end
        end
      end
      S_FAIL: begin
        state_d = S_FAIL;
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase
    if (retry_req || fe_req) begin
      if (retry_q == R_MAX) begin
        state_d = S_FAIL;
      end else begin
        retry_d = retry_q + 8'd1;
        state_d = S_SEND;
        // a rejected argument byte must be preceded by its command again
        if (fe_req && (idx_q == 3'd2 || idx_q == 3'd4))
          idx_d = idx_q - 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_BOOT;
      cnt_q   <= 32'd0;
      idx_q   <= 3'd0;
      retry_q <= 8'd0;
      rate_q  <= 8'd0;
      res_q   <= 2'd0;
      txd_q   <= 8'd0;
      txs_q   <= 1'b0;
      bsy_q   <= 1'b0;
      pb_q    <= 2'd0;
      b0_q    <= 8'd0;
      b1_q    <= 8'd0;
      gap_q   <= 32'd0;
      pv_q    <= 1'b0;
      btn_q   <= 3'd0;
      dx_q    <= 9'd0;
      dy_q    <= 9'd0;
      ovf_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      retry_q <= retry_d;
      rate_q  <= rate_d;
      res_q   <= res_d;
      txd_q   <= txd_d;
      txs_q   <= txs_d;
      bsy_q   <= bsy_d;
      pb_q    <= pb_d;
      b0_q    <= b0_d;
      b1_q    <= b1_d;
      gap_q   <= gap_d;
      pv_q    <= pv_d;
      btn_q   <= btn_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.tx_data   = txd_q;
  assign bus.tx_start  = txs_q;
  assign bus.pkt_valid = pv_q;
  assign bus.pkt_btn   = btn_q;
  assign bus.pkt_dx    = dx_q;
  assign bus.pkt_dy    = dy_q;
  assign bus.pkt_ovf   = ovf_q;
  assign init_done     = (state_q == S_STREAM);
  assign init_fail     = (state_q == S_FAIL);
  assign seq_state     = state_q;

endmodule

// File: tb/tb_ps2_mouse_sequencer.sv
// Scoreboard bench: device model on the slave side, queued
// expectations for sent bytes and decoded packets.
module tb_ps2_mouse_sequencer;
  localparam int BOOT = 20;
  localparam int RTMO = 50;
  localparam int MAXR = 3;
  localparam int PTMO = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] cfg_rate = 8'h64;
  logic [1:0] cfg_res = 2'd2;
  logic       init_done, init_fail;
  logic [3:0] seq_state;

  ps2_mouse_sequencer_if bus();

  ps2_mouse_sequencer #(
    .BOOT_DLY(BOOT), .RSP_TMO(RTMO),
    .MAX_RETRY(MAXR), .PKT_TMO(PTMO)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_rate(cfg_rate), .cfg_res(cfg_res),
    .bus(bus),
    .init_done(init_done), .init_fail(init_fail),
    .seq_state(seq_state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0]  txq[$];
  logic [22:0] pkq[$];
  logic [8:0]  rspq[$];
  bit silent = 0;
  bit fe_once = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // transmitter + mouse model
  initial begin
    logic [7:0] b;
    bus.tx_busy  = 1'b0;
    bus.tx_ack   = 1'b0;
    bus.tx_error = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.tx_start) begin
        b = bus.tx_data;
        bus.tx_busy = 1'b1;
        bus.tx_ack  = 1'b0;
        repeat (3) @(negedge clk);
        bus.tx_busy = 1'b0;
        bus.tx_ack  = 1'b1;
        repeat (2) @(negedge clk);
        if (!silent) begin
          if (b == 8'hFF) begin
            rspq.push_back(9'h0FA);
            rspq.push_back(9'h0AA);
            rspq.push_back(9'h000);
          end else if (b == 8'hF4 && fe_once) begin
            fe_once = 0;
            rspq.push_back(9'h0FE);
          end else begin
            rspq.push_back(9'h0FA);
          end
        end
      end
    end
  end

  // receive-byte driver; bit 8 set means an idle cycle
  initial begin
    logic [8:0] v;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (rspq.size() > 0) begin
        v = rspq.pop_front();
        bus.rx_valid = !v[8];
        bus.rx_data  = v[7:0];
      end else begin
        bus.rx_valid = 1'b0;
      end
    end
  end

  // monitor: sent bytes and packets
  initial begin
    logic [7:0]  eb;
    logic [22:0] ep;
    forever begin
      @(negedge clk);
      if (bus.tx_start) begin
        if (txq.size() == 0) begin
          chk("tx_unexpected", {24'd0, bus.tx_data}, 32'h100);
        end else begin
          eb = txq.pop_front();
          chk("tx_byte", {24'd0, bus.tx_data}, {24'd0, eb});
        end
      end
      if (bus.pkt_valid) begin
        if (pkq.size() == 0) begin
          chk("pkt_unexpected",
              {9'd0, bus.pkt_btn, bus.pkt_dx, bus.pkt_dy, bus.pkt_ovf},
              32'hFFFFFFFF);
        end else begin
          ep = pkq.pop_front();
          chk("pkt", {9'd0, bus.pkt_btn, bus.pkt_dx,
                      bus.pkt_dy, bus.pkt_ovf}, {9'd0, ep});
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic push_init(bit f4_twice);
    txq.push_back(8'hFF);
    txq.push_back(8'hF3);
    txq.push_back(8'h64);
    txq.push_back(8'hE8);
    txq.push_back(8'h02);
    txq.push_back(8'hF4);
    if (f4_twice) txq.push_back(8'hF4);
  endtask

  task automatic wait_done(string nm);
    for (int i = 0; i < 3000 && !init_done; i++) @(negedge clk);
    chk({nm, "_done"}, {31'd0, init_done}, 32'd1);
    chk({nm, "_state"}, {28'd0, seq_state}, 32'd6);
    chk({nm, "_txq"}, txq.size(), 32'd0);
  endtask

  task automatic wait_pk();
    for (int i = 0; i < 500 && (pkq.size() > 0 || rspq.size() > 0); i++)
      @(negedge clk);
    repeat (3) @(negedge clk);
    chk("pkt_drain", pkq.size(), 32'd0);
  endtask

  initial begin
    int cyc;
    int starts;
    // reset values
    repeat (3) @(negedge clk);
    chk("rst_state", {28'd0, seq_state}, 32'd0);
    chk("rst_txs", {31'd0, bus.tx_start}, 32'd0);
    chk("rst_txd", {24'd0, bus.tx_data}, 32'd0);
    chk("rst_flags", {30'd0, init_done, init_fail}, 32'd0);
    chk("rst_pkt", {9'd0, bus.pkt_btn, bus.pkt_dx, bus.pkt_dy,
                    bus.pkt_ovf}, 32'd0);

    // nominal bring-up
    push_init(0);
    rst = 1'b0;
    wait_done("nom");

    // stream packets
    pkq.push_back({3'd1, 9'h005, 9'h0FB, 2'd0});
    rspq.push_back(9'h009);
    rspq.push_back(9'h005);
    rspq.push_back(9'h0FB);
    pkq.push_back({3'd1, 9'h010, 9'h020, 2'd0});
    rspq.push_back(9'h000);
    rspq.push_back(9'h009);
    rspq.push_back(9'h010);
    rspq.push_back(9'h020);
    wait_pk();
    pkq.push_back({3'd0, 9'h101, 9'h002, 2'd0});
    rspq.push_back(9'h008);
    for (int i = 0; i < PTMO + 3; i++) rspq.push_back(9'h100);
    rspq.push_back(9'h018);
    rspq.push_back(9'h001);
    rspq.push_back(9'h002);
    wait_pk();
    repeat (5) @(negedge clk);
    chk("pkt_hold", {14'd0, bus.pkt_valid, bus.pkt_btn, bus.pkt_dx,
                     bus.pkt_dy}, {14'd0, 1'b0, 3'd0, 9'h101, 9'h002});

    // async reset clears packet outputs mid-cycle
    #2 rst = 1'b1;
    #1;
    chk("arst_pkt", {11'd0, bus.pkt_dx, bus.pkt_dy, bus.pkt_btn},
        32'd0);
    chk("arst_state", {28'd0, seq_state}, 32'd0);

    // FE on F4 once
    fe_once = 1;
    push_init(1);
    @(negedge clk);
    rst = 1'b0;
    wait_done("fe");
    chk("fe_retry", {24'd0, dut.retry_q}, 32'd1);

    // silent device after FF
    @(negedge clk);
    rst = 1'b1;
    silent = 1;
    for (int i = 0; i < 4; i++) txq.push_back(8'hFF);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2000 && !init_fail; i++) @(negedge clk);
    chk("sil_fail", {31'd0, init_fail}, 32'd1);
    chk("sil_state", {28'd0, seq_state}, 32'd7);
    chk("sil_txq", txq.size(), 32'd0);
    starts = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.tx_start) starts++;
    end
    chk("sil_quiet", starts, 32'd0);

    // reset during F3 transmission
    rst = 1'b1;
    silent = 0;
    @(negedge clk);
    txq.push_back(8'hFF);
    txq.push_back(8'hF3);
    rst = 1'b0;
    for (int i = 0; i < 500 && txq.size() > 0; i++) @(negedge clk);
    chk("mid_f3_sent", txq.size(), 32'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_txs", {31'd0, bus.tx_start}, 32'd0);
    chk("mid_txd", {24'd0, bus.tx_data}, 32'd0);
    chk("mid_state", {28'd0, seq_state}, 32'd0);
    chk("mid_flags", {30'd0, init_done, init_fail}, 32'd0);
    repeat (10) @(negedge clk);
    push_init(0);
    rst = 1'b0;
    cyc = 0;
    for (int i = 0; i < 500 && txq.size() == 6; i++) begin
      @(negedge clk);
      cyc++;
    end
    chk("boot_wait", {31'd0, cyc >= BOOT}, 32'd1);
    wait_done("mid");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
